denoise_window_filter: RTL and testbench

//  Parametrised successor of the pixel denoiser. Filters a colour-interleaved pixel stream
//  (one channel per beat, channel order 0..NCH-1) with a 1-D sliding window of WIN

---
 rtl/denoise_pkg.sv | 21 ++
 rtl/denoise_sort_win.sv | 34 +++
 rtl/denoise_window_filter.sv | 178 +++++++++++++++++
 tb/tb_denoise_window_filter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/denoise_pkg.sv
// Shared mode codes and parameter helpers for the sliding-window pixel denoiser.
package denoise_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_MEDIAN = 2'd1,
    MODE_MIN    = 2'd2,
    MODE_MAX    = 2'd3
  } mode_e;

  localparam int COLOR_W = 3;

  function automatic logic color_is_void(input logic [COLOR_W-1:0] color, input int nch);
    return int'(color) >= nch;
  endfunction

  function automatic logic win_legal(input int win);
    return (win == 3) || (win == 5);
  endfunction

endpackage

// File: rtl/denoise_sort_win.sv
// Combinational odd-even transposition sorting network over WIN samples; exposes min, median and max.
module denoise_sort_win #(
  parameter int DW  = 8,
  parameter int WIN = 3
) (
  input  logic [WIN*DW-1:0] samples,
  output logic [DW-1:0]     min_out,
  output logic [DW-1:0]     med_out,
  output logic [DW-1:0]     max_out
);

  logic [DW-1:0] s [WIN];
  logic [DW-1:0] tmp;

  // WIN alternating passes of neighbour compare-exchange fully sort WIN elements
  always_comb begin
    tmp = '0;
    for (int i = 0; i < WIN; i++) s[i] = samples[i*DW +: DW];
    for (int p = 0; p < WIN; p++) begin
      for (int i = p % 2; i < WIN - 1; i += 2) begin
        if (s[i] > s[i+1]) begin
          tmp    = s[i];
          s[i]   = s[i+1];
          s[i+1] = tmp;
        end
      end
    end
  end

  assign min_out = s[0];
  assign med_out = s[WIN/2];
  assign max_out = s[WIN-1];

endmodule

// File: rtl/denoise_window_filter.sv
// Per-channel 1-D sliding-window filter (median/min/max/bypass) for a colour-interleaved pixel stream.
module denoise_window_filter
  import denoise_pkg::*;
#(
  parameter int DW  = 8,
  parameter int NCH = 3,
  parameter int WIN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pixel_in,
  input  logic          valid_in,
  input  logic [2:0]    color_in,
  input  logic          last_col_in,
  input  logic [1:0]    mode_in,
  output logic [DW-1:0] pixel_out,
  output logic          valid_out,
  output logic [2:0]    color_out,
  output logic          last_col_out,
  output logic          err
);

  if (!win_legal(WIN)) begin : g_bad_win
    $error("denoise_window_filter: WIN must be 3 or 5");
  end
  if (NCH < 1 || NCH > 7) begin : g_bad_nch
    $error("denoise_window_filter: NCH must be 1..7");
  end

  localparam int          CW       = $clog2(WIN);
  localparam logic [2:0]  VOID     = 3'(NCH);
  localparam logic [2:0]  LAST_CH  = 3'(NCH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIN - 1);

  logic [DW-1:0]  stage [NCH];
  logic [DW-1:0]  win   [NCH][WIN];
  logic [DW-1:0]  res   [NCH];
  logic [DW-1:0]  mn    [NCH];
  logic [DW-1:0]  md    [NCH];
  logic [DW-1:0]  mx    [NCH];
  logic [DW-1:0]  sel   [NCH];
  logic [DW-1:0]  ser_pix;
  logic [2:0]     exp_ch;
  logic [2:0]     ser_idx;
  logic [CW-1:0]  col_cnt;
  mode_e          mode_lat;
  mode_e          mode_eff;
  mode_e          pend_mode;
  logic           line_open;
  logic           pend;
  logic           pend_last;
  logic           res_valid;
  logic           res_last;
  logic           accept;
  logic           order_bad;
  logic           commit;

  assign accept    = valid_in && !color_is_void(color_in, NCH);
  assign order_bad = accept && (color_in != exp_ch);
  assign commit    = accept && !order_bad && (color_in == LAST_CH);
  assign mode_eff  = line_open ? mode_lat : mode_e'(mode_in);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIN*DW-1:0] flat;
    for (genvar i = 0; i < WIN; i++) begin : g_tap
      assign flat[i*DW +: DW] = win[c][i];
    end
    denoise_sort_win #(.DW(DW), .WIN(WIN)) u_sort (
      .samples (flat),
      .min_out (mn[c]),
      .med_out (md[c]),
      .max_out (mx[c])
    );
  end

  // Input side: channel staging, window shift on commit, line bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        stage[c] <= '0;
        for (int i = 0; i < WIN; i++) win[c][i] <= '0;
      end
      exp_ch    <= '0;
      col_cnt   <= '0;
      mode_lat  <= MODE_BYPASS;
      line_open <= 1'b0;
      err       <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      pend_mode <= MODE_BYPASS;
    end else begin
      pend <= 1'b0;
      if (accept) begin
        if (!line_open) begin
          mode_lat  <= mode_e'(mode_in);
          line_open <= 1'b1;
        end
        if (order_bad) begin
          err    <= 1'b1;
          exp_ch <= '0;
        end else if (commit) begin
          for (int c = 0; c < NCH; c++) begin
            win[c][0] <= (c == NCH - 1) ? pixel_in : stage[c];
            for (int i = 1; i < WIN; i++) win[c][i] <= win[c][i-1];
          end
          pend      <= (mode_eff == MODE_BYPASS) || (col_cnt == CNT_FULL);
          pend_last <= last_col_in;
          pend_mode <= mode_eff;
          exp_ch    <= '0;
          if (last_col_in) begin
            col_cnt   <= '0;
            line_open <= 1'b0;
          end else if (col_cnt != CNT_FULL) begin
            col_cnt <= col_cnt + CW'(1);
          end
        end else begin
          for (int c = 0; c < NCH; c++) begin
            if (color_in == 3'(c)) stage[c] <= pixel_in;
          end
          exp_ch <= exp_ch + 3'd1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      case (pend_mode)
        MODE_MEDIAN: sel[c] = md[c];
        MODE_MIN:    sel[c] = mn[c];
        MODE_MAX:    sel[c] = mx[c];
        default:     sel[c] = win[c][0];
      endcase
    end
  end

  always_comb begin
    ser_pix = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ser_idx == 3'(c)) ser_pix = res[c];
    end
  end

  // Result register and NCH-beat serialiser; a new result may land on the final beat of the previous one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) res[c] <= '0;
      res_valid    <= 1'b0;
      res_last     <= 1'b0;
      ser_idx      <= '0;
      pixel_out    <= '0;
      valid_out    <= 1'b0;
      color_out    <= VOID;
      last_col_out <= 1'b0;
    end else begin
      if (pend) begin
        for (int c = 0; c < NCH; c++) res[c] <= sel[c];
        res_last  <= pend_last;
        res_valid <= 1'b1;
      end else if (res_valid && ser_idx == LAST_CH) begin
        res_valid <= 1'b0;
      end
      if (res_valid) begin
        pixel_out    <= ser_pix;
        valid_out    <= 1'b1;
        color_out    <= ser_idx;
        last_col_out <= res_last;
        ser_idx      <= (ser_idx == LAST_CH) ? 3'd0 : ser_idx + 3'd1;
      end else begin
        pixel_out    <= '0;
        valid_out    <= 1'b0;
        color_out    <= VOID;
        last_col_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_denoise_window_filter.sv
// Self-checking bench: table vectors, hand-written corner sequences and random lines against a reference model.
module tb_denoise_window_filter;
  import denoise_pkg::*;

  typedef struct packed {
    logic [7:0] pix;
    logic [2:0] col;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0]      mode;
    logic [3:0]      len;
    logic [0:4][7:0] r;
    logic [3:0]      nexp;
    logic [0:4][7:0] er;
  } vec_t;

  typedef logic [2:0][7:0] pix_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pixel_in;
  logic       valid_in;
  logic [2:0] color_in;
  logic       last_col_in;
  logic [1:0] mode_in;

  logic [7:0] pixel_out3, pixel_out5;
  logic       valid_out3, valid_out5;
  logic [2:0] color_out3, color_out5;
  logic       last_col_out3, last_col_out5;
  logic       err3, err5;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    first_valid_cyc = -1;
  int    commit_cyc[$];
  beat_t got3[$];
  beat_t got5[$];
  pix_t  line_q[$];
  vec_t  vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  denoise_window_filter #(.DW(8), .NCH(3), .WIN(3)) dut3 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in), .color_in(color_in),
    .last_col_in(last_col_in), .mode_in(mode_in), .pixel_out(pixel_out3), .valid_out(valid_out3),
    .color_out(color_out3), .last_col_out(last_col_out3), .err(err3)
  );

  denoise_window_filter #(.DW(8), .NCH(3), .WIN(5)) dut5 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in), .color_in(color_in),
    .last_col_in(last_col_in), .mode_in(mode_in), .pixel_out(pixel_out5), .valid_out(valid_out5),
    .color_out(color_out5), .last_col_out(last_col_out5), .err(err5)
  );

  always @(negedge clk) begin
    if (valid_out3) begin
      got3.push_back({pixel_out3, color_out3, last_col_out3});
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (valid_out5) got5.push_back({pixel_out5, color_out5, last_col_out5});
  end

  task automatic check_val(input string name, input int actual, input int required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, required);
    end
  endtask

  task automatic drive_beat(input logic v, input logic [2:0] col, input logic [7:0] pix,
                            input logic last, input logic [1:0] mode);
    valid_in    = v;
    color_in    = col;
    pixel_in    = pix;
    last_col_in = last;
    mode_in     = mode;
    @(posedge clk);
    #1;
    valid_in    = 1'b0;
    color_in    = 3'd7;
    last_col_in = 1'b0;
  endtask

  task automatic start_line();
    got3.delete();
    got5.delete();
    first_valid_cyc = -1;
    commit_cyc.delete();
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Drives line_q; later beats carry a different mode that must be ignored
  task automatic apply_stimulus(input logic [1:0] mode, input bit noise);
    int n;
    bit first;
    n = line_q.size();
    first = 1'b1;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (noise) begin
          while ($urandom_range(2, 0) == 0) begin
            if ($urandom_range(1, 0) == 1)
              drive_beat(1'b0, 3'(c), 8'($urandom), 1'($urandom), mode ^ 2'b10);
            else
              drive_beat(1'b1, 3'($urandom_range(7, 3)), 8'($urandom), 1'($urandom), mode ^ 2'b10);
          end
        end
        drive_beat(1'b1, 3'(c), line_q[k][c], k == n - 1, first ? mode : mode ^ 2'b01);
        first = 1'b0;
        if (c == 2) commit_cyc.push_back(cyc);
      end
    end
  endtask

  // Reference model: window statistics over committed pixels, one output pixel per full window
  task automatic check_output(input string name, input int win, input logic [1:0] mode);
    beat_t exp_q[$];
    beat_t got_q[$];
    int    w[$];
    int    n;
    int    v;
    if (win == 3) got_q = got3;
    else          got_q = got5;
    n = line_q.size();
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (mode == MODE_BYPASS) begin
          exp_q.push_back({line_q[k][c], 3'(c), k == n - 1});
        end else if (k + win <= n) begin
          w.delete();
          for (int j = 0; j < win; j++) w.push_back(int'(line_q[k+j][c]));
          w.sort();
          if (mode == MODE_MIN)      v = w[0];
          else if (mode == MODE_MAX) v = w[win-1];
          else                       v = w[win/2];
          exp_q.push_back({8'(v), 3'(c), (k + win == n)});
        end
      end
    end
    check_val({name, " beat count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val({name, " beat {pix,col,last}"}, int'(got_q[i]), int'(exp_q[i]));
  endtask

  task automatic load_vec_line(input int idx);
    line_q.delete();
    for (int k = 0; k < int'(vecs[idx].len); k++)
      line_q.push_back({vecs[idx].r[k] + 8'd1, vecs[idx].r[k] + 8'd1, vecs[idx].r[k]});
  endtask

  initial begin
    vecs[0] = '{MODE_MEDIAN, 4'd5, {8'd10, 8'd200, 8'd30, 8'd40, 8'd50}, 4'd3, {8'd30, 8'd40, 8'd40, 8'd0, 8'd0}};
    vecs[1] = '{MODE_MAX,    4'd5, {8'd10, 8'd200, 8'd30, 8'd40, 8'd50}, 4'd3, {8'd200, 8'd200, 8'd50, 8'd0, 8'd0}};
    vecs[2] = '{MODE_MIN,    4'd5, {8'd10, 8'd200, 8'd30, 8'd40, 8'd50}, 4'd3, {8'd10, 8'd30, 8'd30, 8'd0, 8'd0}};
    vecs[3] = '{MODE_BYPASS, 4'd4, {8'd5, 8'd6, 8'd7, 8'd8, 8'd0},       4'd4, {8'd5, 8'd6, 8'd7, 8'd8, 8'd0}};
    vecs[4] = '{MODE_MEDIAN, 4'd2, {8'd1, 8'd2, 8'd0, 8'd0, 8'd0},       4'd0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[5] = '{MODE_MEDIAN, 4'd5, {8'd3, 8'd9, 8'd1, 8'd8, 8'd2},       4'd3, {8'd3, 8'd8, 8'd2, 8'd0, 8'd0}};

    valid_in = 1'b0; color_in = 3'd7; pixel_in = '0; last_col_in = 1'b0; mode_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset pixel_out", pixel_out3, 0);
    check_val("reset valid_out", valid_out3, 0);
    check_val("reset color_out", color_out3, 3);
    check_val("reset last_col_out", last_col_out3, 0);
    check_val("reset err", err3, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      load_vec_line(v);
      start_line();
      apply_stimulus(vecs[v].mode, 1'b0);
      drain();
      check_val($sformatf("vec%0d beat count", v), got3.size(), 3 * int'(vecs[v].nexp));
      for (int k = 0; k < int'(vecs[v].nexp) && 3 * k + 2 < got3.size(); k++) begin
        for (int c = 0; c < 3; c++) begin
          check_val($sformatf("vec%0d px%0d ch%0d", v, k, c), int'(got3[3*k+c]),
                    int'({vecs[v].er[k] + ((c > 0) ? 8'd1 : 8'd0), 3'(c), (k == int'(vecs[v].nexp) - 1)}));
        end
      end
      if (v == 0)
        check_val("first valid_out latency from commit", first_valid_cyc - commit_cyc[2], 2);
    end
    check_val("err after clean lines", err3, 0);

    load_vec_line(0);
    start_line();
    apply_stimulus(MODE_MEDIAN, 1'b1);
    drain();
    check_output("void/gap line", 3, MODE_MEDIAN);
    check_val("err after void/gap line", err3, 0);

    line_q.delete();
    line_q.push_back({8'd10, 8'd10, 8'd9});
    line_q.push_back({8'd2, 8'd2, 8'd1});
    line_q.push_back({8'd6, 8'd6, 8'd5});
    line_q.push_back({8'd8, 8'd8, 8'd7});
    line_q.push_back({8'd4, 8'd4, 8'd3});
    start_line();
    apply_stimulus(MODE_MEDIAN, 1'b0);
    drain();
    check_val("win5 beat count", got5.size(), 3);
    if (got5.size() == 3) begin
      check_val("win5 R median", got5[0].pix, 5);
      check_val("win5 G median", got5[1].pix, 6);
      check_val("win5 last_col_out", got5[2].last, 1);
    end

    start_line();
    drive_beat(1'b1, 3'd0, 8'd10, 1'b0, MODE_MEDIAN);
    drive_beat(1'b1, 3'd2, 8'd11, 1'b0, MODE_MEDIAN);
    check_val("err after R,B order", err3, 1);
    line_q.delete();
    line_q.push_back({8'd201, 8'd201, 8'd200});
    line_q.push_back({8'd31, 8'd31, 8'd30});
    line_q.push_back({8'd41, 8'd41, 8'd40});
    line_q.push_back({8'd51, 8'd51, 8'd50});
    apply_stimulus(MODE_MEDIAN, 1'b0);
    drain();
    check_val("order error output beats", got3.size(), 6);
    check_output("order error line", 3, MODE_MEDIAN);
    load_vec_line(5);
    start_line();
    apply_stimulus(MODE_MEDIAN, 1'b0);
    drain();
    check_val("err sticky", err3, 1);
    check_output("line after order error", 3, MODE_MEDIAN);

    start_line();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 3; c++)
        drive_beat(1'b1, 3'(c), 8'(20 * k + c), 1'b0, MODE_MAX);
    drive_beat(1'b1, 3'd0, 8'd77, 1'b0, MODE_MAX);
    drive_beat(1'b1, 3'd1, 8'd78, 1'b0, MODE_MAX);
    check_val("valid_out in flight before rst", valid_out3, 1);
    rst = 1'b1;
    #1;
    check_val("async rst pixel_out", pixel_out3, 0);
    check_val("async rst valid_out", valid_out3, 0);
    check_val("async rst color_out", color_out3, 3);
    check_val("async rst last_col_out", last_col_out3, 0);
    check_val("async rst err", err3, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    load_vec_line(0);
    start_line();
    apply_stimulus(MODE_MEDIAN, 1'b0);
    drain();
    check_output("line after rst", 3, MODE_MEDIAN);

    for (int t = 0; t < 12; t++) begin
      logic [1:0] m;
      int len;
      m = 2'($urandom_range(3, 0));
      len = $urandom_range(7, 1);
      line_q.delete();
      for (int k = 0; k < len; k++) line_q.push_back(24'($urandom));
      start_line();
      apply_stimulus(m, 1'($urandom));
      drain();
      check_output($sformatf("random line %0d win3", t), 3, m);
      check_output($sformatf("random line %0d win5", t), 5, m);
    end
    check_val("err after random lines", err3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
